// File: rtl/common.sv
// Shared constants and types for the execute/memory stages: branch and
// load/store funct3 encodings, the LSU state enum and lane helpers.
package common;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_type;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_op_type;

  // funct3[1:0] encodes access width for both loads and stores
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] data);
    case (sz)
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic size_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      size_illegal = (f3 >= 3'b011);
    end else begin
      size_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    is_misaligned = ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a read word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import common::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension
  always_comb begin
    byte_s = rdata[{offset, 3'b000} +: 8];
    half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{byte_s[7]}}, byte_s};
      LH:      data = {{16{half_s[15]}}, half_s};
      LW:      data = rdata;
      LBU:     data = {24'h000000, byte_s};
      LHU:     data = {16'h0000, half_s};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one operation in flight over a req/gnt/rvalid port,
// returning aligned load data or store completion, with error reporting.
module load_store_unit
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        ctrl_mem_write,
  input  logic        ctrl_mem2reg,
  input  logic [2:0]  ctrl_word_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_reg_write,
  output logic        resp_error,
  output logic        resp_misaligned
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  lsu_state_type state_r, state_nx_s;
  lsu_op_type    op_r, op_s;
  logic [CW-1:0] cnt_r;
  logic          accept_s, illegal_s, misal_s, timeout_s;
  logic          err_nx_s, mis_nx_s, reg_wr_nx_s;
  logic [31:0]   data_nx_s, aligned_s;

  load_align u_align (
    .funct3 (op_r.size),
    .offset (op_r.addr[1:0]),
    .rdata  (mem_rdata),
    .data   (aligned_s)
  );

  assign req_ready = (state_r == LSU_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready && (ctrl_mem_write || ctrl_mem2reg);
  assign timeout_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // Next-state, operation capture and response selection
  always_comb begin
    state_nx_s  = state_r;
    op_s        = op_r;
    illegal_s   = 1'b0;
    misal_s     = 1'b0;
    err_nx_s    = 1'b0;
    mis_nx_s    = 1'b0;
    reg_wr_nx_s = 1'b0;
    data_nx_s   = 32'h0000_0000;
    case (state_r)
      LSU_IDLE: begin
        if (accept_s) begin
          op_s.we    = ctrl_mem_write;
          op_s.size  = ctrl_word_size;
          op_s.addr  = addr;
          op_s.wdata = store_data;
          op_s.rd    = rd_addr;
          illegal_s  = size_illegal(ctrl_mem_write, ctrl_word_size);
          misal_s    = is_misaligned(ctrl_word_size[1:0], addr[1:0]);
          if (illegal_s || misal_s) begin
            state_nx_s = LSU_RESP;
            err_nx_s   = 1'b1;
            mis_nx_s   = misal_s && !illegal_s;
          end else begin
            state_nx_s = LSU_REQ;
          end
        end else begin
          state_nx_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        // A store grant on the last allowed cycle still counts as completion
        if (mem_gnt && op_r.we) begin
          state_nx_s = LSU_RESP;
        end else if (timeout_s) begin
          state_nx_s = LSU_RESP;
          err_nx_s   = 1'b1;
        end else if (mem_gnt) begin
          state_nx_s = LSU_WAIT;
        end else begin
          state_nx_s = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid) begin
          state_nx_s  = LSU_RESP;
          data_nx_s   = aligned_s;
          reg_wr_nx_s = 1'b1;
        end else if (timeout_s) begin
          state_nx_s = LSU_RESP;
          err_nx_s   = 1'b1;
        end else begin
          state_nx_s = LSU_WAIT;
        end
      end
      LSU_RESP: state_nx_s = LSU_IDLE;
      default:  state_nx_s = LSU_IDLE;
    endcase
  end

  // State, captured operation, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= LSU_IDLE;
      op_r            <= '0;
      cnt_r           <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'h0000_0000;
      mem_wdata       <= 32'h0000_0000;
      mem_be          <= 4'b0000;
      resp_valid      <= 1'b0;
      resp_data       <= 32'h0000_0000;
      resp_rd         <= 5'd0;
      resp_reg_write  <= 1'b0;
      resp_error      <= 1'b0;
      resp_misaligned <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      op_r    <= op_s;
      if ((state_nx_s == LSU_REQ) && (state_r != LSU_REQ)) begin
        cnt_r <= '0;
      end else if ((state_r == LSU_REQ) || (state_r == LSU_WAIT)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      mem_req   <= (state_nx_s == LSU_REQ);
      mem_we    <= (state_nx_s == LSU_REQ) && op_s.we;
      mem_addr  <= (state_nx_s == LSU_REQ) ? {op_s.addr[31:2], 2'b00} : 32'h0000_0000;
      mem_be    <= (state_nx_s == LSU_REQ) ? lane_mask(op_s.size[1:0], op_s.addr[1:0]) : 4'b0000;
      mem_wdata <= ((state_nx_s == LSU_REQ) && op_s.we) ?
                   store_lanes(op_s.size[1:0], op_s.wdata) : 32'h0000_0000;
      resp_valid      <= (state_nx_s == LSU_RESP);
      resp_data       <= data_nx_s;
      resp_rd         <= (state_nx_s == LSU_RESP) ? op_s.rd : 5'd0;
      resp_reg_write  <= reg_wr_nx_s;
      resp_error      <= err_nx_s;
      resp_misaligned <= mis_nx_s;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit plus hand sequences for
// neither-flag handshakes, timeouts and reset during WAIT.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic        ctrl_mem_write, ctrl_mem2reg;
  logic [2:0]  ctrl_word_size;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_addr;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, resp_reg_write, resp_error, resp_misaligned;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .ctrl_mem_write(ctrl_mem_write), .ctrl_mem2reg(ctrl_mem2reg),
    .ctrl_word_size(ctrl_word_size), .addr(addr), .store_data(store_data),
    .rd_addr(rd_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_reg_write(resp_reg_write),
    .resp_error(resp_error), .resp_misaligned(resp_misaligned)
  );

  typedef struct {
    logic        we;
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_delay;
    logic        err;
    logic        mis;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    req_valid = 1'b1; ctrl_mem_write = we; ctrl_mem2reg = ld;
    ctrl_word_size = f3; addr = a; store_data = sd; rd_addr = rd;
    tick();
    req_valid = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b0;
    addr = 32'h0; store_data = 32'h0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [4:0] rd;
    rd = 5'(i + 1);
    drive_req(v.we, v.ld, v.f3, v.a, v.sdata, rd);
    if (v.err) begin
      chk($sformatf("v%0d err_req", i), {31'b0, mem_req}, 32'd0);
      chk($sformatf("v%0d err_valid", i), {resp_valid, resp_error, resp_misaligned, resp_reg_write},
          {1'b1, 1'b1, v.mis, 1'b0});
      chk($sformatf("v%0d err_data", i), resp_data, 32'h0);
    end else begin
      chk($sformatf("v%0d req", i), {mem_req, mem_we}, {1'b1, v.we});
      chk($sformatf("v%0d addr", i), mem_addr, v.exp_addr);
      chk($sformatf("v%0d be", i), {28'b0, mem_be}, {28'b0, v.exp_be});
      chk($sformatf("v%0d wdata", i), mem_wdata, v.exp_wdata);
      for (int k = 0; k < v.gnt_delay; k++) begin
        tick();
        chk($sformatf("v%0d hold_req", i), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d hold_addr", i), mem_addr, v.exp_addr);
        chk($sformatf("v%0d hold_wdata", i), mem_wdata, v.exp_wdata);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      if (!v.we) begin
        chk($sformatf("v%0d wait", i), {mem_req, resp_valid}, 2'b00);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
      chk($sformatf("v%0d resp", i), {resp_valid, resp_error, resp_reg_write, mem_req},
          {1'b1, 1'b0, !v.we, 1'b0});
      chk($sformatf("v%0d data", i), resp_data, v.exp_data);
    end
    chk($sformatf("v%0d rd", i), {27'b0, resp_rd}, {27'b0, rd});
    tick();
    chk($sformatf("v%0d idle", i), {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    // we ld f3 addr sdata rdata delay err mis exp_data exp_addr exp_wdata be
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h1003, 32'h0, 32'h8000_0000, 0, 1'b0, 1'b0, 32'hFFFF_FF80, 32'h1000, 32'h0, 4'b1000};
    vecs[1]  = '{1'b1, 1'b0, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 1'b0, 1'b0, 32'h0, 32'h2000, 32'hABCD_ABCD, 4'b1100};
    vecs[2]  = '{1'b0, 1'b1, 3'b010, 32'h2001, 32'h0, 32'h0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 3'b101, 32'h3002, 32'h0, 32'hBEEF_0000, 1, 1'b0, 1'b0, 32'h0000_BEEF, 32'h3000, 32'h0, 4'b1100};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h4001, 32'h0000_00A5, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h4000, 32'hA5A5_A5A5, 4'b0010};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h5000, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0, 32'h0, 32'h5000, 32'hDEAD_BEEF, 4'b1111};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h6002, 32'h0, 32'h8001_0000, 0, 1'b0, 1'b0, 32'hFFFF_8001, 32'h6000, 32'h0, 4'b1100};
    vecs[7]  = '{1'b0, 1'b1, 3'b100, 32'h7002, 32'h0, 32'h00FE_0000, 0, 1'b0, 1'b0, 32'h0000_00FE, 32'h7000, 32'h0, 4'b0100};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h8000, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b0, 32'h1234_5678, 32'h8000, 32'h0, 4'b1111};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h9001, 32'h0, 32'h0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[10] = '{1'b0, 1'b1, 3'b011, 32'hA000, 32'h0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[11] = '{1'b1, 1'b0, 3'b100, 32'hB000, 32'h0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'hC004, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'hC004, 32'h0BAD_F00D, 4'b1111};
    vecs[13] = '{1'b0, 1'b1, 3'b001, 32'hD000, 32'h0, 32'hFFFF_7FFF, 0, 1'b0, 1'b0, 32'h0000_7FFF, 32'hD000, 32'h0, 4'b0011};

    rst = 1'b1; req_valid = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b0;
    ctrl_word_size = 3'b000; addr = 32'h0; store_data = 32'h0; rd_addr = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    chk("reset_ctrl", {req_ready, mem_req, mem_we, resp_valid, resp_reg_write, resp_error, resp_misaligned}, 7'b0);
    chk("reset_bus", mem_addr | mem_wdata | resp_data | {28'b0, mem_be} | {27'b0, resp_rd}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
    end

    // Handshake with neither flag is ignored
    drive_req(1'b0, 1'b0, 3'b010, 32'hE000, 32'h0, 5'd3);
    chk("noflag_idle", {mem_req, resp_valid, req_ready}, 3'b001);
    tick();
    chk("noflag_noresp", {31'b0, resp_valid}, 32'd0);

    // Load timeout in WAIT: REQ cnt0 (granted), WAIT cnt1..3, RESP next
    drive_req(1'b0, 1'b1, 3'b010, 32'h0100, 32'h0, 5'd9);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    tick();
    chk("to_not_early", {resp_valid, mem_req}, 2'b00);
    tick();
    chk("to_resp", {resp_valid, resp_error, resp_misaligned, resp_reg_write}, 4'b1100);
    chk("to_data", resp_data, 32'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_1", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("late_rvalid_2", {resp_valid, req_ready}, 2'b01);

    // Store never granted: mem_req held for 4 cycles then dropped with error
    drive_req(1'b1, 1'b0, 3'b010, 32'h0200, 32'h7777_7777, 5'd4);
    tick();
    tick();
    tick();
    chk("to_store_req", {mem_req, resp_valid}, 2'b10);
    tick();
    chk("to_store_resp", {mem_req, resp_valid, resp_error, resp_misaligned}, 4'b0110);
    tick();

    // Reset while in WAIT abandons the load
    drive_req(1'b0, 1'b1, 3'b000, 32'h0300, 32'h0, 5'd7);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_wait_out", {mem_req, resp_valid, req_ready}, 3'b000);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
    tick();
    chk("rst_hold_out", {mem_req, resp_valid, req_ready}, 3'b000);
    rst = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
    tick();
    chk("rst_no_resp", {resp_valid, mem_req}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between execute and writeback. Captures one memory operation per request, using the ALU address, rs2 store data and the control-unit flags `ctrl_mem_write`, `ctrl_mem2reg` and `ctrl_word_size`. It drives a single-outstanding request/grant/rvalid data-memory port and returns an aligned, sign- or zero-extended load result, or a store completion, to writeback. Misaligned accesses, illegal sizes and memory timeouts are reported as errors and never reach memory.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum number of cycles spent in REQ+WAIT before the unit aborts with an error; must be ≥2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: execute stage presents an operation.
- `req_ready` out 1: high only in IDLE while `rst`=0.
- `ctrl_mem_write` in 1: operation is a store.
- `ctrl_mem2reg` in 1: operation is a load.
- `ctrl_word_size` in 3: funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rs2 value.
- `rd_addr` in 5: load destination register.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: extended load value; 0 for stores and errors.
- `resp_rd` out 5: captured `rd_addr`.
- `resp_reg_write` out 1: write `resp_data` to `resp_rd`; set only for loads without error.
- `resp_error` out 1: misaligned, illegal size, or timeout.
- `resp_misaligned` out 1: error cause is misalignment.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **Accept:** accept when `req_valid && req_ready && (ctrl_mem_write || ctrl_mem2reg)`. On accept, capture all inputs. If both flags are set, the request is a store. Handshakes with neither flag set are ignored; the unit stays in IDLE.
- **Checks at accept:**
  - Illegal size: load funct3 ∈ {011,110,111}, or store funct3 ≥ 011.
  - Misalignment: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Either check failing sends IDLE→RESP with `resp_error`=1 and `mem_req` never asserted. `resp_misaligned`=1 only for the misalignment cause.
- **Legal request:** IDLE→REQ.
- **REQ:** `mem_req`=1 and the remaining `mem_*` outputs are stable until `mem_gnt`.
  - Store with grant → RESP.
  - Load with grant → WAIT.
- **WAIT:** `mem_rvalid` → capture the extracted data, then RESP. `mem_rvalid` is only observed in WAIT.
- **RESP:** `resp_*` valid for exactly one cycle, then IDLE.
- **Store lanes:**
  - SB: `mem_be`=`4'b0001<<addr[1:0]`, `mem_wdata`={4{data[7:0]}}.
  - SH: `mem_be`=`addr[1]`?1100:0011, `mem_wdata`={2{data[15:0]}}.
  - SW: `mem_be`=1111.
- **Load extraction:** select the byte at `addr[1:0]` or the half at `addr[1]`. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through. Loads drive `mem_be` = the lane mask as for stores and `mem_wdata`=0.
- **Timeout:** a counter clears on entering REQ and increments each cycle in REQ or WAIT. When it reaches `TIMEOUT_CYCLES-1` without completion, the next state is RESP with `resp_error`=1 and `mem_req` dropped. A late `mem_rvalid` arriving in any other state is ignored.

## Timing
- **Reset:** `rst`=1 forces IDLE at the next edge. All outputs are 0 during and after reset, including `req_ready`, until the first cycle with `rst`=0.
- **Reset mid-operation:** the operation is abandoned, `mem_req` falls at the next edge and no `resp_valid` is produced.
- **Latency, accept at cycle T:**
  - Store granted at T+1: `resp_valid` at T+2.
  - Load granted at T+1 with `mem_rvalid` at T+2: `resp_valid` at T+3.
  - Error at accept: `resp_valid` at T+1.
- One operation is in flight; the next accept is earliest in the cycle after RESP.
- `resp_valid` has no backpressure.

## Structure
- Package `common` holds:
  - the funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW, alongside the existing BEQ and related constants;
  - `lsu_state_type` enum.
- Sub-module `load_align`: combinational funct3 + `addr[1:0]` + `mem_rdata` → extended word. It is reused by the forwarding logic.

## Test plan
- **Load byte, signed:** LB at `addr`=0x1003, `mem_rdata`=0x80_00_00_00 → `resp_data`=0xFFFFFF80, `resp_reg_write`=1, `mem_addr`=0x1000, `mem_be`=1000.
- **Store halfword:** SH at `addr`=0x2002, `store_data`=0x1234ABCD, `mem_gnt` delayed 3 cycles → `mem_be`=1100, `mem_wdata`=0xABCDABCD held stable; `resp_valid` the cycle after grant with `resp_reg_write`=0.
- **Misaligned word:** LW at `addr`=0x2001 → `mem_req` never high; `resp_valid`=`resp_error`=`resp_misaligned`=1 at T+1.
- **Timeout:** `TIMEOUT_CYCLES`=4 with no `mem_rvalid` after grant → `resp_error`=1 and `resp_misaligned`=0; a `mem_rvalid` arriving afterward produces no response.
- **Reset in WAIT:** assert `rst` → `mem_req` and `resp_valid` stay 0, `req_ready` is 0 during reset and 1 after release.
- **LHU:** `addr`=0x3002, `mem_rdata`=0xBEEF0000 → `resp_data`=0x0000BEEF.
